step_rate_monitor: RTL
======================

STEP_RATE_MONITOR -- requirements
Module: step_rate_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, fastclk cycles a raw step level must hold stable before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter HIGH_THRESH, default 64, minimum steps in one window for that window to count as high activity.
REQ-003 fastclk  input  1  single system clock, 100 MHz; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 slowclk  input  1  2 s period square wave from the divider stage, already in the fastclk domain; a window boundary is each 0->1 transition.
REQ-006 step_raw  input  1  raw pedometer/button level, asynchronous to fastclk, may bounce.
REQ-007 total_steps  output  14  saturating running step count.
REQ-008 window_steps  output  8  step count of the last completed window.
REQ-009 window_valid  output  1  one-cycle pulse when window_steps updates.
REQ-010 high_secs  output  16  saturating seconds spent in high-activity windows.

Function
REQ-011 step_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce FSM SHALL have states LOW, RISE_WAIT, HIGH, FALL_WAIT; LOW->RISE_WAIT on sync=1; RISE_WAIT->HIGH after DEBOUNCE_CYCLES consecutive cycles of sync=1, else back to LOW on sync=0; HIGH->FALL_WAIT on sync=0; FALL_WAIT->LOW after DEBOUNCE_CYCLES consecutive cycles of sync=0, else back to HIGH on sync=1.
REQ-013 A one-cycle step strobe SHALL fire on the RISE_WAIT->HIGH transition only; no strobe on any other transition.
REQ-014 Step strobe SHALL increment total_steps by 1, saturating at 9999.
REQ-015 Step strobe SHALL increment the internal window accumulator by 1, saturating at 255.
REQ-016 slowclk rising edge SHALL be detected via a registered copy; the boundary fires the cycle after slowclk is first sampled 1.
REQ-017 On a boundary cycle: window_steps <= accumulator, window_valid <= 1 for exactly that next cycle, accumulator <= 0.
REQ-018 On a boundary where the latched count >= HIGH_THRESH, high_secs SHALL increase by 2, saturating at 65535 (65534+2 -> 65535).
REQ-019 Step strobe coincident with a boundary SHALL count in the new window (accumulator <= 1) and in total_steps; the closing window excludes it.
REQ-020 slowclk falling edges SHALL have no effect.
REQ-021 The first boundary after reset SHALL report a partial window as normal; no special casing.
REQ-022 Latency: step strobe to total_steps update 1 cycle; boundary detect to window_steps/window_valid 1 cycle.

Reset
REQ-023 reset_n low SHALL immediately clear: total_steps=0, window_steps=0, window_valid=0, high_secs=0, accumulator=0, debounce FSM=LOW, debounce counter=0, synchronizer and slowclk-history flops=0.
REQ-024 Reset asserted mid-debounce or mid-window SHALL discard the partial step and partial window; no strobe or window_valid on release.
REQ-025 Reset deassertion SHALL be usable directly; after release a slowclk already high SHALL NOT generate a boundary until its next 0->1 transition.

Structure
REQ-026 Shared package fitbit_pkg SHALL hold TOTAL_W=14, TOTAL_MAX=9999, WIN_W=8, HIGH_W=16, and the debounce state encodings.
REQ-027 Debounce logic (synchronizer, FSM, counter, strobe) SHALL be a sub-module step_debounce; the top holds counters and window logic.

Verification (DEBOUNCE_CYCLES=4, HIGH_THRESH=3 in sim)
REQ-028 Clean step_raw high 10 cycles then low 10 cycles, repeated 5 times -> total_steps=5, exactly 5 strobes.
REQ-029 step_raw toggling every 2 cycles for 40 cycles, then settling low -> total_steps unchanged, FSM ends in LOW.
REQ-030 4 steps then slowclk 0->1, then 1 step then next rise -> window_steps 4 with window_valid, then 1; high_secs=2 after the first window and unchanged after the second.
REQ-031 Step strobe forced on the boundary cycle with 2 prior steps -> window_steps=2, next window reports 1 more than its other steps, total_steps +3.
REQ-032 Preload total_steps to 9998 and drive 3 steps -> 9999; 300 steps in one window -> window_steps=255.
REQ-033 reset_n pulsed low mid-RISE_WAIT with slowclk high -> all outputs 0, no strobe, no window_valid until the next slowclk rise.

Source files
------------

// File: rtl/fitbit_pkg.sv
// Shared widths, limits and debounce state encoding for the step-rate monitor.
package fitbit_pkg;

    localparam int unsigned TOTAL_W   = 14;
    localparam int unsigned TOTAL_MAX = 9999;
    localparam int unsigned WIN_W     = 8;
    localparam int unsigned WIN_MAX   = 255;
    localparam int unsigned HIGH_W    = 16;
    localparam int unsigned HIGH_INC  = 2;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_RISE_WAIT = 2'd1,
        DB_HIGH      = 2'd2,
        DB_FALL_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/step_debounce.sv
// Synchronizes and debounces the raw step level; emits one strobe per accepted rising level.
module step_debounce
    import fitbit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic fastclk,
    input  logic reset_n,
    input  logic i_step_raw,
    output logic o_step_strobe
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_strobe;
    logic             w_strobe_nxt;
    logic             w_sync;

    assign w_sync        = r_sync[1];
    assign o_step_strobe = r_strobe;

    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b00;
            r_state  <= DB_LOW;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_step_raw};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    // Counter tracks consecutive stable cycles while waiting in either *_WAIT state
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = '0;
        w_strobe_nxt = 1'b0;
        case (r_state)
            DB_LOW: begin
                if (w_sync) w_state_nxt = DB_RISE_WAIT;
            end
            DB_RISE_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = DB_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = DB_HIGH;
                    w_strobe_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DB_HIGH: begin
                if (!w_sync) w_state_nxt = DB_FALL_WAIT;
            end
            DB_FALL_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = DB_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_LOW;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = DB_LOW;
        endcase
    end

endmodule

// File: rtl/step_rate_monitor.sv
// Step counter with 2 s activity windows: running total, per-window count and high-activity seconds.
module step_rate_monitor
    import fitbit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HIGH_THRESH     = 64
) (
    input  logic               fastclk,
    input  logic               reset_n,
    input  logic               slowclk,
    input  logic               step_raw,
    output logic [TOTAL_W-1:0] total_steps,
    output logic [WIN_W-1:0]   window_steps,
    output logic               window_valid,
    output logic [HIGH_W-1:0]  high_secs
);

    logic               w_step_strobe;
    logic               w_boundary;
    logic               r_slow_q;
    logic               r_slow_d;
    logic [1:0]         r_primed;
    logic [TOTAL_W-1:0] r_total_steps;
    logic [TOTAL_W-1:0] w_total_nxt;
    logic [WIN_W-1:0]   r_acc;
    logic [WIN_W-1:0]   w_acc_nxt;
    logic [WIN_W-1:0]   r_window_steps;
    logic [WIN_W-1:0]   w_win_nxt;
    logic               r_window_valid;
    logic               w_valid_nxt;
    logic [HIGH_W-1:0]  r_high_secs;
    logic [HIGH_W-1:0]  w_high_nxt;
    logic [HIGH_W:0]    w_high_sum;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .fastclk       (fastclk),
        .reset_n       (reset_n),
        .i_step_raw    (step_raw),
        .o_step_strobe (w_step_strobe)
    );

    // Boundary is held off until both history flops carry real samples, so a
    // slowclk already high at reset release is not mistaken for a rising edge.
    assign w_boundary = r_primed[1] & r_slow_q & ~r_slow_d;
    assign w_high_sum = (HIGH_W + 1)'(r_high_secs) + (HIGH_W + 1)'(HIGH_INC);

    always_comb begin
        w_total_nxt = r_total_steps;
        w_acc_nxt   = r_acc;
        w_win_nxt   = r_window_steps;
        w_valid_nxt = 1'b0;
        w_high_nxt  = r_high_secs;
        if (w_step_strobe && (r_total_steps != TOTAL_W'(TOTAL_MAX))) begin
            w_total_nxt = r_total_steps + TOTAL_W'(1);
        end
        if (w_boundary) begin
            w_win_nxt   = r_acc;
            w_valid_nxt = 1'b1;
            w_acc_nxt   = w_step_strobe ? WIN_W'(1) : '0;
            if (32'(r_acc) >= HIGH_THRESH) begin
                w_high_nxt = w_high_sum[HIGH_W] ? '1 : w_high_sum[HIGH_W-1:0];
            end
        end else if (w_step_strobe && (r_acc != WIN_W'(WIN_MAX))) begin
            w_acc_nxt = r_acc + WIN_W'(1);
        end
    end

    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            r_slow_q       <= 1'b0;
            r_slow_d       <= 1'b0;
            r_primed       <= 2'b00;
            r_total_steps  <= '0;
            r_acc          <= '0;
            r_window_steps <= '0;
            r_window_valid <= 1'b0;
            r_high_secs    <= '0;
        end else begin
            r_slow_q       <= slowclk;
            r_slow_d       <= r_slow_q;
            r_primed       <= {r_primed[0], 1'b1};
            r_total_steps  <= w_total_nxt;
            r_acc          <= w_acc_nxt;
            r_window_steps <= w_win_nxt;
            r_window_valid <= w_valid_nxt;
            r_high_secs    <= w_high_nxt;
        end
    end

    assign total_steps  = r_total_steps;
    assign window_steps = r_window_steps;
    assign window_valid = r_window_valid;
    assign high_secs    = r_high_secs;

endmodule
